aes_spi_rx: RTL and testbench
=============================

# aes_spi_rx

SPI-slave front end for the AES core. Deserialises one MSB-first frame on `mosi` into a 128-bit data block followed by an Nk·32-bit key. The active chip select gives the direction: `cs1` means encrypt, `cs2` means decrypt. The block then presents block, key and mode to the cipher core over a valid/ready handshake. It sits directly downstream of the SPI master pins and upstream of the round logic.

## Interface
- `Nk`, 4, key length in 32-bit words (4/6/8 → AES-128/192/256); frame length L = 128 + 32·Nk bits
- `clk`  in  1  serial clock (SPI `sclk`); all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cs1`  in  1  chip select, encrypt channel, active-high
- `cs2`  in  1  chip select, decrypt channel, active-high
- `mosi`  in  1  serial data, sampled on rising `clk`
- `out_valid`  out  1  block/key/mode ready for core
- `out_ready`  in  1  core accepts
- `out_mode`  out  1  0 = encrypt, 1 = decrypt
- `out_block`  out  128  data block (first 128 bits received)
- `out_key`  out  Nk·32  key (last Nk·32 bits received)
- `frame_err`  out  1  one-cycle pulse on malformed frame
- `overrun`  out  1  one-cycle pulse when a frame is dropped because the output is still held

## Operation
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- "Single select" means exactly one of `cs1`/`cs2` is high.
- FSM states: IDLE, SHIFT, HOLD, DRAIN.
- IDLE → SHIFT on a single select:
  - that cycle's `mosi` is bit 0;
  - mode is latched (`cs2` → 1);
  - bit counter is set to 1.
- IDLE with both selects high → `frame_err` pulse, go to DRAIN.
- SHIFT, while the same single select stays high: shift `mosi` into the LSB of an L-bit register and increment the counter.
- When the counter reaches L, go to HOLD and assert `out_valid`. Bit 0 ends up at `out_block[127]`; the final bit ends up at `out_key[0]`.
- SHIFT with any other select combination before L bits → abort:
  - `frame_err` pulse;
  - go to IDLE if both selects are low, otherwise DRAIN;
  - partial data is discarded and outputs are unchanged.
- HOLD:
  - outputs are stable while `out_valid=1`;
  - on `out_valid & out_ready`, leave HOLD: to IDLE if both selects are low, else to DRAIN;
  - any select high while in HOLD is a new frame. Pulse `overrun` once, on the first such cycle only. That frame is dropped, including bits after the handshake completes, via DRAIN.
- DRAIN: ignore `mosi`; return to IDLE when both selects are low.
- Selects still high after L bits (over-long frame): extra bits are ignored. This is not an error.

## Timing
- Reset values: `out_valid`=0, `out_mode`=0, `out_block`=0, `out_key`=0, `frame_err`=0, `overrun`=0. FSM goes to IDLE; the stored-key flag is cleared.
- Latency: the last bit is sampled at edge N. `out_valid` is high after edge N+1 (registered).
- Handshake: the transfer happens on the edge where `out_valid & out_ready`. `out_valid` is low after that edge.
- A new frame may start on the edge after the handshake if both selects were low in between. Minimum frame-to-frame gap is one idle cycle.
- `rst` mid-frame or mid-HOLD: abort without a pulse. All outputs go to their reset values on the next edge.
- Bit counter width is clog2(L+1). The counter never wraps, because it saturates on entry to HOLD.

## Configuration
- `AES_SPI_RX_KEY_REUSE_EN`
- Defined:
  - a completed frame stores its key and sets a key-valid flag;
  - a frame that ends (both selects low) after exactly 128 bits, with the flag set, completes as a normal frame: the new block goes out with the stored key;
  - with the flag clear, a 128-bit frame is a `frame_err`.
- Undefined: any frame shorter than L bits is a `frame_err`. No key storage is synthesised.

## Structure
- `aes_pkg`:
  - `NK_DEFAULT`;
  - a frame-length function of Nk;
  - a mode enum (ENCRYPT=0, DECRYPT=1);
  - the rx FSM state enum.
- One sub-module, `aes_spi_shreg`: an L-bit shift register plus saturating bit counter, with shift-enable, clear, count output and parallel output. The FSM stays in `aes_spi_rx`.

## Test plan
- Encrypt frame: `cs1`=1 for 256 cycles; block 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; `out_ready`=1. Expected: `out_valid` one cycle after the last bit, `out_mode`=0, exact block and key, no error pulses.
- Decrypt frame with backpressure: `cs2`=1, block 69c4e0d86a7b0430d8cdb78070b4c55a, same key; `out_ready` held low for 10 cycles. Expected: `out_mode`=1, outputs stable throughout, `out_valid` low the cycle after `out_ready` rises.
- Abort: drop `cs1` after 100 bits. Expected: one `frame_err` pulse, `out_valid` stays 0, the next full frame is received correctly.
- Overrun: start a `cs1` frame while HOLD is pending. Expected: one `overrun` pulse; that frame is never presented even after `out_ready`; the following frame is received correctly.
- Both selects high at frame start. Expected: `frame_err` pulse, DRAIN until both low. Also: `rst` pulsed at bit 200. Expected: no output, clean reception of the next frame.
- With `AES_SPI_RX_KEY_REUSE_EN` defined: a full frame, then a 128-bit frame with block 000102030405060708090a0b0c0d0e0f. Expected: the second output carries the first key. Without the macro, the same 128-bit frame gives `frame_err`.

Source files
------------

// File: rtl/aes_spi_rx_pkg.sv
// Shared types and constants for the AES SPI receive front end.
package aes_pkg;

  localparam int NK_DEFAULT = 4;
  localparam int BLOCK_BITS = 128;

  typedef enum logic {
    ENCRYPT = 1'b0,
    DECRYPT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DRAIN
  } rx_state_e;

  function automatic int frame_len(input int nk);
    return BLOCK_BITS + 32 * nk;
  endfunction

endpackage

// File: rtl/aes_spi_rx_if.sv
// Block/key/mode handoff from the SPI receiver to the cipher core.
interface aes_spi_rx_if
  import aes_pkg::*;
#(
  parameter int NK = NK_DEFAULT
);
  logic                 out_valid;
  logic                 out_ready;
  mode_e                out_mode;
  logic [BLOCK_BITS-1:0] out_block;
  logic [32*NK-1:0]     out_key;

  modport master (output out_valid, out_mode, out_block, out_key, input out_ready);
  modport slave  (input out_valid, out_mode, out_block, out_key, output out_ready);
endinterface

// File: rtl/aes_spi_rx_shreg.sv
// MSB-first frame shift register with a bit counter that saturates at the frame length.
module aes_spi_shreg #(
  parameter int L = 256,
  localparam int CW = $clog2(L + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          shift,
  input  logic          clear,
  input  logic          din,
  output logic [L-1:0]  data,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data  <= '0;
      count <= '0;
    end else if (start) begin
      data  <= {{(L-1){1'b0}}, din};
      count <= CW'(1);
    end else if (shift && (count < CW'(L))) begin
      data  <= {data[L-2:0], din};
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/aes_spi_rx.sv
// SPI-slave receiver: deserialises block+key, presents them with mode over valid/ready.
// Optional short-frame key reuse is enabled by defining AES_SPI_RX_KEY_REUSE_EN.
module aes_spi_rx
  import aes_pkg::*;
#(
  parameter int Nk = NK_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic cs1,
  input  logic cs2,
  input  logic mosi,
  aes_spi_rx_if.master core,
  output logic frame_err,
  output logic overrun
);
  // state | meaning
  // IDLE  | waiting for a single select to open a frame
  // SHIFT | collecting frame bits while the same select stays high
  // HOLD  | block/key presented, waiting for the core to accept
  // DRAIN | discarding an errored or dropped frame until both selects fall

  localparam int L  = frame_len(Nk);
  localparam int K  = 32 * Nk;
  localparam int CW = $clog2(L + 1);

  rx_state_e      state, state_nx;
  mode_e          frame_mode;
  logic [L-1:0]   data;
  logic [CW-1:0]  count;
  logic           sr_start, sr_shift, sr_clear;
  logic           load_full, load_short, err_nx, ovr_nx;
  logic           tail, ovr_seen;
  logic           none_sel, single_sel, same_sel, reuse_ok;

  assign none_sel   = !cs1 && !cs2;
  assign single_sel = cs1 ^ cs2;
  assign same_sel   = (frame_mode == DECRYPT) ? (cs2 && !cs1) : (cs1 && !cs2);

`ifdef AES_SPI_RX_KEY_REUSE_EN
  logic key_ok;
  assign reuse_ok = none_sel && (count == CW'(BLOCK_BITS)) && key_ok;

  always_ff @(posedge clk) begin
    if (rst)            key_ok <= 1'b0;
    else if (load_full) key_ok <= 1'b1;
  end
`else
  assign reuse_ok = 1'b0;
`endif

  aes_spi_shreg #(.L(L)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .start (sr_start),
    .shift (sr_shift),
    .clear (sr_clear),
    .din   (mosi),
    .data  (data),
    .count (count)
  );

  always_comb begin
    state_nx   = state;
    sr_start   = 1'b0;
    sr_shift   = 1'b0;
    sr_clear   = 1'b0;
    load_full  = 1'b0;
    load_short = 1'b0;
    err_nx     = 1'b0;
    ovr_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (single_sel) begin
          sr_start = 1'b1;
          state_nx = SHIFT;
        end else if (cs1 && cs2) begin
          err_nx   = 1'b1;
          state_nx = DRAIN;
        end
      end
      SHIFT: begin
        if (count == CW'(L)) begin
          load_full = 1'b1;
          state_nx  = HOLD;
        end else if (same_sel) begin
          sr_shift = 1'b1;
        end else if (reuse_ok) begin
          load_short = 1'b1;
          state_nx   = HOLD;
        end else begin
          err_nx   = 1'b1;
          sr_clear = 1'b1;
          state_nx = none_sel ? IDLE : DRAIN;
        end
      end
      HOLD: begin
        // A select seen after the frame's own tail has ended belongs to a new frame
        if (!tail && !none_sel && !ovr_seen) ovr_nx = 1'b1;
        if (core.out_ready) state_nx = none_sel ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (none_sel) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      frame_mode     <= ENCRYPT;
      core.out_valid <= 1'b0;
      core.out_mode  <= ENCRYPT;
      core.out_block <= '0;
      core.out_key   <= '0;
      frame_err      <= 1'b0;
      overrun        <= 1'b0;
      tail           <= 1'b0;
      ovr_seen       <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_err <= err_nx;
      overrun   <= ovr_nx;
      if (sr_start) frame_mode <= cs2 ? DECRYPT : ENCRYPT;
      if (load_full || load_short) begin
        core.out_valid <= 1'b1;
        core.out_mode  <= frame_mode;
        core.out_block <= load_full ? data[L-1 -: BLOCK_BITS] : data[BLOCK_BITS-1:0];
        // out_key only changes on full frames, so it already holds the key a short frame reuses
        if (load_full) core.out_key <= data[K-1:0];
        tail     <= !none_sel;
        ovr_seen <= 1'b0;
      end else if (state == HOLD) begin
        if (none_sel) tail <= 1'b0;
        if (ovr_nx) ovr_seen <= 1'b1;
        if (core.out_ready) core.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_spi_rx.sv
// Self-checking bench for aes_spi_rx: directed spec vectors plus randomized frames.
module tb_aes_spi_rx;
  import aes_pkg::*;

  localparam int NK = NK_DEFAULT;
  localparam int L  = frame_len(NK);
  localparam int K  = 32 * NK;

  logic clk = 1'b0;
  logic rst, cs1, cs2, mosi;
  logic frame_err, overrun;

  aes_spi_rx_if #(.NK(NK)) bus ();

  aes_spi_rx #(.Nk(NK)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs1       (cs1),
    .cs2       (cs2),
    .mosi      (mosi),
    .core      (bus.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         mode;
    logic [127:0] block;
    logic [K-1:0] key;
  } txn_t;

  txn_t rx_q[$];
  int   err_cnt = 0, ovr_cnt = 0, exp_err = 0, exp_ovr = 0;
  int   checks = 0, errors = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready)
        rx_q.push_back({logic'(bus.out_mode), bus.out_block, bus.out_key});
      if (frame_err) err_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic c1, input logic c2, input logic [L-1:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      cs1  = c1;
      cs2  = c2;
      mosi = (i < L) ? bits[L-1-i] : logic'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic idle(input int n);
    cs1  = 1'b0;
    cs2  = 1'b0;
    mosi = 1'b0;
    repeat (n) tick();
  endtask

  task automatic expect_txn(input string tag, input logic m, input logic [127:0] b,
                            input logic [K-1:0] k);
    txn_t r;
    int   t = 0;
    while (rx_q.size() == 0 && t < 600) begin
      tick();
      t++;
    end
    chk({tag, "_present"}, 256'(rx_q.size() != 0), 256'(1));
    if (rx_q.size() != 0) begin
      r = rx_q.pop_front();
      chk({tag, "_mode"}, 256'(r.mode), 256'(m));
      chk({tag, "_block"}, 256'(r.block), 256'(b));
      chk({tag, "_key"}, 256'(r.key), 256'(k));
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frame_err_count"}, 256'(err_cnt), 256'(exp_err));
    chk({tag, "_overrun_count"}, 256'(ovr_cnt), 256'(exp_ovr));
    chk({tag, "_extra_frames"}, 256'(rx_q.size()), 256'(0));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [K-1:0] rand_key();
    logic [K-1:0] k;
    for (int i = 0; i < NK; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  task automatic rand_frame(input string tag);
    logic         m;
    logic [127:0] b;
    logic [K-1:0] k;
    int           bp;
    m  = logic'($urandom_range(0, 1));
    b  = rand128();
    k  = rand_key();
    bp = $urandom_range(0, 4);
    bus.out_ready = (bp == 0);
    send(!m, m, {b, k}, L);
    idle(1);
    if (bp > 0) begin
      repeat (bp) begin
        chk({tag, "_hold_valid"}, 256'(bus.out_valid), 256'(1));
        chk({tag, "_hold_block"}, 256'(bus.out_block), 256'(b));
        tick();
      end
      bus.out_ready = 1'b1;
      tick();
      chk({tag, "_valid_drop"}, 256'(bus.out_valid), 256'(0));
    end
    expect_txn(tag, m, b, k);
    check_counts(tag);
    idle($urandom_range(1, 3));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] b1, b2, b3, ba, bf;
    logic [K-1:0] k1, ka, kf;
    b1 = 128'h00112233445566778899aabbccddeeff;
    b2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    b3 = 128'h000102030405060708090a0b0c0d0e0f;
    k1 = K'(128'h000102030405060708090a0b0c0d0e0f);

    rst = 1'b1; cs1 = 1'b0; cs2 = 1'b0; mosi = 1'b0; bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_mode", 256'(bus.out_mode), 256'(0));
    chk("rst_block", 256'(bus.out_block), 256'(0));
    chk("rst_key", 256'(bus.out_key), 256'(0));
    chk("rst_frame_err", 256'(frame_err), 256'(0));
    chk("rst_overrun", 256'(overrun), 256'(0));

    // encrypt frame, ready high
    bus.out_ready = 1'b1;
    send(1'b1, 1'b0, {b1, k1}, L);
    chk("enc_valid_at_last_bit", 256'(bus.out_valid), 256'(0));
    idle(1);
    chk("enc_valid", 256'(bus.out_valid), 256'(1));
    chk("enc_mode", 256'(bus.out_mode), 256'(ENCRYPT));
    chk("enc_block", 256'(bus.out_block), 256'(b1));
    chk("enc_key", 256'(bus.out_key), 256'(k1));
    idle(1);
    chk("enc_valid_after_hs", 256'(bus.out_valid), 256'(0));
    expect_txn("enc", 1'b0, b1, k1);
    check_counts("enc");

    // decrypt frame with 10 cycles of backpressure
    bus.out_ready = 1'b0;
    send(1'b0, 1'b1, {b2, k1}, L);
    idle(1);
    for (int i = 0; i < 10; i++) begin
      chk("dec_hold_valid", 256'(bus.out_valid), 256'(1));
      chk("dec_hold_mode", 256'(bus.out_mode), 256'(DECRYPT));
      chk("dec_hold_block", 256'(bus.out_block), 256'(b2));
      chk("dec_hold_key", 256'(bus.out_key), 256'(k1));
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("dec_valid_after_hs", 256'(bus.out_valid), 256'(0));
    expect_txn("dec", 1'b1, b2, k1);
    check_counts("dec");
    idle(1);

    // abort after 100 bits
    send(1'b1, 1'b0, {rand128(), rand_key()}, 100);
    idle(3);
    exp_err++;
    chk("abort_valid", 256'(bus.out_valid), 256'(0));
    chk("abort_block_kept", 256'(bus.out_block), 256'(b2));
    check_counts("abort");
    rand_frame("after_abort");

    // overrun: new frame starts while HOLD is pending
    bus.out_ready = 1'b0;
    ba = rand128();
    ka = rand_key();
    send(1'b1, 1'b0, {ba, ka}, L);
    idle(2);
    send(1'b1, 1'b0, {rand128(), rand_key()}, 30);
    bus.out_ready = 1'b1;
    send(1'b1, 1'b0, {rand128(), rand_key()}, L - 30);
    idle(2);
    exp_ovr++;
    expect_txn("ovr_held", 1'b0, ba, ka);
    check_counts("ovr");
    rand_frame("after_ovr");

    // both selects at frame start
    cs1 = 1'b1; cs2 = 1'b1;
    repeat (5) begin
      mosi = logic'($urandom_range(0, 1));
      tick();
    end
    idle(2);
    exp_err++;
    check_counts("both_sel");
    rand_frame("after_both");

    // reset at bit 200
    bus.out_ready = 1'b1;
    send(1'b1, 1'b0, {rand128(), rand_key()}, 200);
    rst = 1'b1; cs1 = 1'b0; cs2 = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 256'(bus.out_valid), 256'(0));
    chk("midrst_block", 256'(bus.out_block), 256'(0));
    chk("midrst_key", 256'(bus.out_key), 256'(0));
    idle(2);
    check_counts("midrst");
    rand_frame("after_rst");

    // over-long frame is accepted without error
    bf = rand128();
    kf = rand_key();
    bus.out_ready = 1'b1;
    send(1'b1, 1'b0, {bf, kf}, L + 6);
    idle(2);
    expect_txn("overlong", 1'b0, bf, kf);
    check_counts("overlong");

    // 128-bit frame after a full frame
    send(1'b1, 1'b0, {b3, K'(0)}, 128);
    idle(3);
`ifdef AES_SPI_RX_KEY_REUSE_EN
    expect_txn("short", 1'b0, b3, kf);
`else
    exp_err++;
`endif
    check_counts("short");

    for (int i = 0; i < 12; i++) rand_frame("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
